spm_operand_sequencer: RTL

//   Upstream feeder and result collector for the 8x8 signed serial multiplier.
//   - Buffers operand pairs from a valid/ready source in a small FIFO.
//   - Runs one multiplication at a time:
//     - drives x/y and the multiplier's rst;
//     - waits for done;
//     - presents the 16-bit product on a valid/ready output.
//   - A watchdog flags a multiplier that never raises done.

---
 rtl/spm_operand_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spm_operand_sequencer.sv
// Feeds buffered operand pairs to the serial multiplier one at a time and returns products on a valid/ready port.
// Latency: one IDLE cycle plus L RUN cycles to out_valid; in_ready low when the FIFO is full, result held until out_ready.
module spm_operand_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_x,
  input  logic [7:0]               in_y,
  output logic                     mul_rst,
  output logic [7:0]               mul_x,
  output logic [7:0]               mul_y,
  input  logic [15:0]              mul_prod,
  input  logic                     mul_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_prod,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [7:0]    WD_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    fx [DEPTH];
  logic [7:0]    fy [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    wdog;
  logic          push, pop, timeout;

  assign in_ready  = fifo_cnt != CNT_FULL;
  assign push      = in_valid && in_ready;
  // Pop looks at the registered count, so a pair entering an empty FIFO waits one edge.
  assign pop       = (state == IDLE) && (fifo_cnt != '0);
  assign timeout   = wdog == WD_LAST;
  assign mul_rst   = state != RUN;
  assign out_valid = state == OUT;
  assign busy      = (state != IDLE) || (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fx[wr_ptr] <= in_x;
      fy[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_cnt != '0) state_nxt = RUN;
      RUN:     if (mul_done || timeout) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands load while mul_rst is still high so the multiplier starts on settled inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x    <= '0;
      mul_y    <= '0;
      out_prod <= '0;
      out_err  <= 1'b0;
      wdog     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mul_x <= fx[rd_ptr];
            mul_y <= fy[rd_ptr];
            wdog  <= '0;
          end
        end
        RUN: begin
          wdog <= wdog + 8'd1;
          if (mul_done) begin
            out_prod <= mul_prod;
            out_err  <= 1'b0;
          end else if (timeout) begin
            out_prod <= '0;
            out_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
